// File: rtl/ed25519_pkg.sv
// Field constants for GF(2^255-19), the point_to_affine state type and the
// pseudo-Mersenne fold used by the shared modular multiplier.
package ed25519_pkg;

  localparam int FIELD_W = 255;
  localparam logic [FIELD_W-1:0] P_MOD   = {FIELD_W{1'b1}} - FIELD_W'(18);
  localparam logic [FIELD_W-1:0] INV_EXP = P_MOD - FIELD_W'(2);

  localparam int DIGIT_W    = 32;
  localparam int MUL_DIGITS = 8;
  localparam int ACC_W      = FIELD_W + DIGIT_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    SQR,
    MUL,
    STEP,
    FIN_X,
    FIN_Y,
    DONE
  } p2a_state_t;

  // v < 2^33 * p; 2^255 == 19 (mod p), so one fold leaves t < 2p.
  function automatic logic [FIELD_W-1:0] fold_reduce(input logic [ACC_W-1:0] v);
    logic [FIELD_W:0] t;
    t = {1'b0, v[FIELD_W-1:0]} + (FIELD_W+1)'(v[ACC_W-1:FIELD_W]) * (FIELD_W+1)'(19);
    if (t >= {1'b0, P_MOD}) t = t - {1'b0, P_MOD};
    return t[FIELD_W-1:0];
  endfunction

endpackage

// File: rtl/point_to_affine_if.sv
// Request/result bundle of point_to_affine. o_enc exists only when
// POINT_ENCODE_EN is defined.
interface point_to_affine_if;
  import ed25519_pkg::*;

  logic               i_start;
  logic [FIELD_W-1:0] i_x;
  logic [FIELD_W-1:0] i_y;
  logic [FIELD_W-1:0] i_z;
  logic [FIELD_W-1:0] o_x;
  logic [FIELD_W-1:0] o_y;
`ifdef POINT_ENCODE_EN
  logic [FIELD_W:0]   o_enc;
`endif
  logic               o_busy;
  logic               o_zero;
  logic               o_valid;

`ifdef POINT_ENCODE_EN
  modport master (output i_start, i_x, i_y, i_z,
                  input  o_x, o_y, o_enc, o_busy, o_zero, o_valid);
  modport slave  (input  i_start, i_x, i_y, i_z,
                  output o_x, o_y, o_enc, o_busy, o_zero, o_valid);
`else
  modport master (output i_start, i_x, i_y, i_z,
                  input  o_x, o_y, o_busy, o_zero, o_valid);
  modport slave  (input  i_start, i_x, i_y, i_z,
                  output o_x, o_y, o_busy, o_zero, o_valid);
`endif

endinterface

// File: rtl/point_to_affine_mod_mul.sv
// Sequential a*b mod p: Horner over 32-bit digits of b, MSB digit first.
// o_done pulses 9 cycles after i_start; o_p holds until the next i_start.
module mod_mul
  import ed25519_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [FIELD_W-1:0] i_a,
  input  logic [FIELD_W-1:0] i_b,
  output logic [FIELD_W-1:0] o_p,
  output logic               o_done
);

  localparam int CNT_W = $clog2(MUL_DIGITS);
  localparam int B_W   = MUL_DIGITS * DIGIT_W;

  logic [FIELD_W-1:0] a_q;
  logic [FIELD_W-1:0] r_q;
  logic [FIELD_W-1:0] r_d;
  logic [B_W-1:0]     b_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [ACC_W-1:0]   acc_wide;

  always_comb begin
    acc_wide = ACC_W'({r_q, {DIGIT_W{1'b0}}})
             + ACC_W'(a_q) * ACC_W'(b_q[B_W-1 -: DIGIT_W]);
    r_d = fold_reduce(acc_wide);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q    <= '0;
      r_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (i_start && !busy_q) begin
        a_q    <= i_a;
        b_q    <= B_W'(i_b);
        r_q    <= '0;
        cnt_q  <= CNT_W'(MUL_DIGITS - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        r_q <= r_d;
        b_q <= b_q << DIGIT_W;
        if (cnt_q == '0) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
    end
  end

  assign o_p    = r_q;
  assign o_done = done_q;

endmodule

// File: rtl/point_to_affine.sv
// Extended (X,Y,Z) -> affine (x,y) via Z^(p-2) on one shared multiplier.
// Define POINT_ENCODE_EN to add the registered compressed encoding o_enc.
module point_to_affine
  import ed25519_pkg::*;
(
  input logic              i_clk,
  input logic              i_rst,
  point_to_affine_if.slave bus
);

  // state | meaning
  // IDLE  | waiting for i_start (ignored in the o_valid cycle)
  // SQR   | acc = acc^2; first entry spends one cycle launching
  // MUL   | acc = acc * Z, taken when exponent bit k is 1
  // STEP  | next exponent bit, or leave the ladder after bit 0
  // FIN_X | x = X * acc
  // FIN_Y | y = Y * acc
  // DONE  | commit outputs with the o_valid pulse

  p2a_state_t         state_q;
  logic [7:0]         k_q;
  logic               launch_q;
  logic               mul_start_q;
  logic [FIELD_W-1:0] x_in_q, y_in_q, z_q, acc_q;
  logic [FIELD_W-1:0] x_q, y_q;
  logic [FIELD_W-1:0] o_x_q, o_y_q;
  logic               busy_q, zero_q, valid_q;
`ifdef POINT_ENCODE_EN
  logic [FIELD_W:0]   o_enc_q;
`endif

  logic [FIELD_W-1:0] mul_a, mul_b, mul_p;
  logic               mul_done;

  always_comb begin
    mul_a = acc_q;
    mul_b = acc_q;
    case (state_q)
      MUL:     mul_b = z_q;
      FIN_X:   mul_a = x_in_q;
      FIN_Y:   mul_a = y_in_q;
      default: ;
    endcase
  end

  mod_mul u_mod_mul (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (mul_start_q),
    .i_a     (mul_a),
    .i_b     (mul_b),
    .o_p     (mul_p),
    .o_done  (mul_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      launch_q    <= 1'b0;
      mul_start_q <= 1'b0;
      x_in_q      <= '0;
      y_in_q      <= '0;
      z_q         <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      o_x_q       <= '0;
      o_y_q       <= '0;
      busy_q      <= 1'b0;
      zero_q      <= 1'b0;
      valid_q     <= 1'b0;
`ifdef POINT_ENCODE_EN
      o_enc_q     <= '0;
`endif
    end else begin
      mul_start_q <= 1'b0;
      valid_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.i_start && !valid_q) begin
            x_in_q   <= bus.i_x;
            y_in_q   <= bus.i_y;
            z_q      <= bus.i_z;
            acc_q    <= bus.i_z;
            k_q      <= 8'd253;
            launch_q <= 1'b1;
            busy_q   <= 1'b1;
            zero_q   <= 1'b0;
            state_q  <= SQR;
          end
        end
        SQR: begin
          if (launch_q) begin
            launch_q    <= 1'b0;
            mul_start_q <= 1'b1;
          end else if (mul_done) begin
            acc_q <= mul_p;
            if (INV_EXP[k_q]) begin
              state_q     <= MUL;
              mul_start_q <= 1'b1;
            end else begin
              state_q <= STEP;
            end
          end
        end
        MUL: begin
          if (mul_done) begin
            acc_q   <= mul_p;
            state_q <= STEP;
          end
        end
        STEP: begin
          mul_start_q <= 1'b1;
          if (k_q == '0) begin
            state_q <= FIN_X;
          end else begin
            k_q     <= k_q - 8'd1;
            state_q <= SQR;
          end
        end
        FIN_X: begin
          if (mul_done) begin
            x_q         <= mul_p;
            state_q     <= FIN_Y;
            mul_start_q <= 1'b1;
          end
        end
        FIN_Y: begin
          if (mul_done) begin
            y_q     <= mul_p;
            state_q <= DONE;
          end
        end
        DONE: begin
          // Z = 0 inverts to 0, so x_q/y_q are already 0 in that case.
          o_x_q   <= x_q;
          o_y_q   <= y_q;
`ifdef POINT_ENCODE_EN
          o_enc_q <= {x_q[0], y_q};
`endif
          zero_q  <= (z_q == '0);
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_x     = o_x_q;
  assign bus.o_y     = o_y_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_zero  = zero_q;
  assign bus.o_valid = valid_q;
`ifdef POINT_ENCODE_EN
  assign bus.o_enc   = o_enc_q;
`endif

endmodule

// File: tb/tb_point_to_affine.sv
// Bench for point_to_affine: directed table, random operands against an
// arithmetic model, plus busy-ignore and mid-run reset sequences.
module tb_point_to_affine;

  localparam logic [254:0] P = {255{1'b1}} - 255'd18;
  localparam int L_MUL   = 9;
  localparam int EXP_LAT = 508 * (L_MUL + 1) + 254 + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  point_to_affine_if bus_if ();

  point_to_affine dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [254:0] x, y, z, ex, ey;
    logic         ez;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [254:0] mulmod(input logic [254:0] a, input logic [254:0] b);
    logic [511:0] t;
    t = 512'(a) * 512'(b);
    t = t % 512'(P);
    return t[254:0];
  endfunction

  // right-to-left binary exponentiation
  function automatic logic [254:0] powmod(input logic [254:0] base, input logic [254:0] e);
    logic [254:0] r, b;
    r = 255'd1;
    b = base;
    for (int i = 0; i < 255; i++) begin
      if (e[i]) r = mulmod(r, b);
      b = mulmod(b, b);
    end
    return r;
  endfunction

  function automatic logic [254:0] rand_fe();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    t = t % {1'b0, P};
    return t[254:0];
  endfunction

  task automatic run_conv(input logic [254:0] x, y, z, input logic poke,
                          output logic [254:0] gx, gy, output logic gz,
                          output logic [255:0] genc, output int lat,
                          output logic busy1, output logic single, output logic busy_after);
    @(negedge clk);
    bus_if.i_x     = x;
    bus_if.i_y     = y;
    bus_if.i_z     = z;
    bus_if.i_start = 1'b1;
    @(negedge clk);
    bus_if.i_start = 1'b0;
    lat   = 1;
    busy1 = bus_if.o_busy;
    while (!bus_if.o_valid && lat < EXP_LAT + 50) begin
      if (poke && lat == 100) begin
        bus_if.i_start = 1'b1;
        bus_if.i_x     = x ^ 255'd1;
        bus_if.i_y     = y ^ 255'd2;
        bus_if.i_z     = 255'd3;
      end else begin
        bus_if.i_start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    gx = bus_if.o_x;
    gy = bus_if.o_y;
    gz = bus_if.o_zero;
`ifdef POINT_ENCODE_EN
    genc = bus_if.o_enc;
`else
    genc = '0;
`endif
    bus_if.i_start = poke;
    @(negedge clk);
    bus_if.i_start = 1'b0;
    single = !bus_if.o_valid;
    @(negedge clk);
    busy_after = bus_if.o_busy;
  endtask

  task automatic run_and_check(input string tag, input logic [254:0] x, y, z,
                               input logic [254:0] ex, ey, input logic ez, input logic poke);
    logic [254:0] gx, gy;
    logic         gz, busy1, single, busy_after;
    logic [255:0] genc;
    int           lat;
    run_conv(x, y, z, poke, gx, gy, gz, genc, lat, busy1, single, busy_after);
    check({tag, "/x"}, 256'(gx), 256'(ex));
    check({tag, "/y"}, 256'(gy), 256'(ey));
    check({tag, "/zero"}, 256'(gz), 256'(ez));
    check({tag, "/latency"}, 256'(lat), 256'(EXP_LAT));
    check({tag, "/busy_after_start"}, 256'(busy1), 256'd1);
    check({tag, "/single_valid"}, 256'(single), 256'd1);
    check({tag, "/idle_after_valid"}, 256'(busy_after), 256'd0);
`ifdef POINT_ENCODE_EN
    check({tag, "/enc"}, genc, {ex[0], ey});
`endif
  endtask

  initial begin
    logic [254:0] rx, ry, rz, mx, my, inv;
    int           nvalid;

    bus_if.i_start = 1'b0;
    bus_if.i_x     = '0;
    bus_if.i_y     = '0;
    bus_if.i_z     = '0;
    repeat (3) @(negedge clk);
    check("reset/o_x", 256'(bus_if.o_x), 256'd0);
    check("reset/o_y", 256'(bus_if.o_y), 256'd0);
    check("reset/o_busy", 256'(bus_if.o_busy), 256'd0);
    check("reset/o_zero", 256'(bus_if.o_zero), 256'd0);
    check("reset/o_valid", 256'(bus_if.o_valid), 256'd0);
`ifdef POINT_ENCODE_EN
    check("reset/o_enc", bus_if.o_enc, 256'd0);
`endif
    rst = 1'b0;

    tbl[0] = '{x: 255'd5,  y: 255'd7, z: 255'd1,  ex: 255'd1 * 5, ey: 255'd7, ez: 1'b0};
    tbl[1] = '{x: 255'd2,  y: 255'd4, z: 255'd2,  ex: 255'd1, ey: 255'd2, ez: 1'b0};
    tbl[2] = '{x: P - 255'd1, y: 255'd1, z: P - 255'd1, ex: 255'd1, ey: P - 255'd1, ez: 1'b0};
    tbl[3] = '{x: 255'd3,  y: 255'd3, z: 255'd0,  ex: 255'd0, ey: 255'd0, ez: 1'b1};
    tbl[4] = '{x: 255'd1,  y: 255'd4, z: 255'd1,  ex: 255'd1, ey: 255'd4, ez: 1'b0};

    for (int i = 0; i < 5; i++)
      run_and_check($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].z,
                    tbl[i].ex, tbl[i].ey, tbl[i].ez, 1'b0);

    run_and_check("busy_poke", 255'd5, 255'd7, 255'd1, 255'd5, 255'd7, 1'b0, 1'b1);

    for (int r = 0; r < 3; r++) begin
      rx = rand_fe();
      ry = rand_fe();
      rz = rand_fe();
      if (rz == '0) rz = 255'd11;
      inv = powmod(rz, P - 255'd2);
      mx  = mulmod(rx, inv);
      my  = mulmod(ry, inv);
      run_and_check($sformatf("rand%0d", r), rx, ry, rz, mx, my, 1'b0, 1'b0);
    end

    @(negedge clk);
    bus_if.i_x     = 255'd9;
    bus_if.i_y     = 255'd11;
    bus_if.i_z     = 255'd13;
    bus_if.i_start = 1'b1;
    @(negedge clk);
    bus_if.i_start = 1'b0;
    repeat (998) @(negedge clk);
    check("abort/busy_before", 256'(bus_if.o_busy), 256'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort/o_x", 256'(bus_if.o_x), 256'd0);
    check("abort/o_y", 256'(bus_if.o_y), 256'd0);
    check("abort/o_busy", 256'(bus_if.o_busy), 256'd0);
    check("abort/o_zero", 256'(bus_if.o_zero), 256'd0);
    check("abort/o_valid", 256'(bus_if.o_valid), 256'd0);
`ifdef POINT_ENCODE_EN
    check("abort/o_enc", bus_if.o_enc, 256'd0);
`endif
    nvalid = 0;
    repeat (EXP_LAT) begin
      @(negedge clk);
      if (bus_if.o_valid) nvalid++;
    end
    check("abort/no_valid", 256'(nvalid), 256'd0);
    check("abort/idle", 256'(bus_if.o_busy), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
